// File: rtl/leaf_rr_dispatch.sv
// leaf_rr_dispatch: FIFO-buffered round-robin dispatcher of work words to NUM_LEAVES leaves (optional LEAF_DISPATCH_CNT_EN adds dispatch_cnt)
module leaf_rr_dispatch #(
    parameter int NUM_LEAVES = 5,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_LEAVES-1:0]   out_valid,
    input  logic [NUM_LEAVES-1:0]   out_ready,
    output logic [DATA_W-1:0]       out_data,
`ifdef LEAF_DISPATCH_CNT_EN
    output logic [31:0]             dispatch_cnt,
`endif
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(NUM_LEAVES);
    typedef enum logic {EMPTY, PRESENT} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] next_tgt;
    logic push, xfer, load;
    assign in_ready = fifo_level != LW'(DEPTH);
    assign push = in_valid && in_ready;
    assign xfer = |(out_valid & out_ready);
    assign load = !flush && fifo_level != '0 && (state == EMPTY || xfer);
    // word storage; stale entries after flush are never read because pointers reset
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;
    // FIFO pointers and occupancy; a pop is exactly an output-register load
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(load);
        end
    // output register FSM: present head to the next leaf in rotation, hold while stalled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            next_tgt  <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= '0;
            next_tgt  <= '0;
        end else if (load) begin
            state     <= PRESENT;
            out_valid <= NUM_LEAVES'(1) << next_tgt;
            out_data  <= mem[rd_ptr];
            next_tgt  <= (next_tgt == TW'(NUM_LEAVES - 1)) ? '0 : next_tgt + 1'b1;
        end else if (xfer) begin
            state     <= EMPTY;
            out_valid <= '0;
        end
`ifdef LEAF_DISPATCH_CNT_EN
    // count completed transfers; a transfer coinciding with flush is dropped and not counted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dispatch_cnt <= '0;
        else if (flush) dispatch_cnt <= '0;
        else if (xfer) dispatch_cnt <= dispatch_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_leaf_rr_dispatch.sv
// tb_leaf_rr_dispatch: randomized self-checking bench with a word/leaf-order scoreboard
module tb_leaf_rr_dispatch;
    localparam int N = 5;
    localparam int W = 16;
    localparam int D = 4;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0;
    logic in_ready;
    logic [W-1:0] in_data = '0;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready = '0;
    logic [W-1:0] out_data;
    logic [2:0] fifo_level;
`ifdef LEAF_DISPATCH_CNT_EN
    logic [31:0] dispatch_cnt;
`endif
    leaf_rr_dispatch #(.NUM_LEAVES(N), .DATA_W(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef LEAF_DISPATCH_CNT_EN
        .dispatch_cnt(dispatch_cnt),
`endif
        .fifo_level(fifo_level)
    );
    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [W-1:0] q[$];
    int exp_leaf = 0;
    logic [31:0] exp_cnt = '0;
    logic got_xfer, did_push;
    logic [N-1:0] got_vec, exp_vec;
    logic [W-1:0] got_data, exp_data;

    // reference model: k-th word delivered since reset/flush is the k-th accepted word and goes to leaf k mod N
    task automatic tick();
        got_xfer = (|(out_valid & out_ready)) && !flush;
        did_push = in_valid && in_ready;
        got_vec = out_valid;
        got_data = out_data;
        exp_vec = '0;
        exp_data = 'x;
        if (got_xfer) begin
            exp_vec = N'(1) << exp_leaf;
            if (q.size() > 0) exp_data = q.pop_front();
            exp_leaf = (exp_leaf + 1) % N;
            exp_cnt = exp_cnt + 32'd1;
        end
        if (flush) begin
            q.delete();
            exp_leaf = 0;
            exp_cnt = '0;
        end else if (did_push) q.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; flush = 0; out_ready = '0;
        @(negedge clk);
        q.delete(); exp_leaf = 0; exp_cnt = '0;
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== '0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
        total++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        rst_n = 1;
    endtask

    task automatic test_order();
        int pushed = 0, delivered = 0, fp = -1, fv = -1;
        out_ready = '1;
        for (int c = 0; c < 40 && (pushed < 7 || q.size() > 0 || out_valid != '0); c++) begin
            in_valid = pushed < 7;
            in_data = W'(pushed + 1);
            tick();
            if (did_push && fp < 0) fp = c;
            if (did_push) pushed++;
            if (out_valid != '0 && fv < 0) fv = c;
            if (got_xfer) begin
                delivered++;
                total++;
                if (got_vec !== exp_vec || got_data !== exp_data)
                    $display("FAIL order_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
                else passed++;
            end
        end
        in_valid = 0;
        total++; if (delivered !== 7) $display("FAIL order_count: got %0d want 7", delivered); else passed++;
        total++; if (fv - fp !== 1) $display("FAIL latency: out_valid %0d edges after push, want 1", fv - fp); else passed++;
    endtask

    int nxt;
    task automatic test_stall();
        int delivered = 0;
        do_reset();
        out_ready = ~(N'(1) << 2);
        nxt = 1;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1;
            in_data = W'(nxt);
            tick();
            if (did_push) nxt++;
            if (got_xfer) begin
                delivered++;
                total++;
                if (got_vec !== exp_vec || got_data !== exp_data)
                    $display("FAIL stall_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
                else passed++;
            end
        end
        total++; if (delivered !== 2) $display("FAIL stall_delivered: got %0d want 2", delivered); else passed++;
        total++; if (out_valid !== 5'b00100) $display("FAIL stall_valid: got %b want 00100", out_valid); else passed++;
        total++; if (out_data !== 16'h0003) $display("FAIL stall_data: got %h want 0003", out_data); else passed++;
        total++; if (fifo_level !== 3'd4) $display("FAIL stall_level: got %0d want 4", fifo_level); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else passed++;
    endtask

    task automatic test_full_pop();
        out_ready = '1;
        in_valid = 1;
        in_data = W'(nxt);
        total++; if (in_ready !== 1'b0) $display("FAIL fullpop_ready_same_cycle: got %b want 0", in_ready); else passed++;
        tick();
        total++;
        if (!got_xfer || got_vec !== exp_vec || got_data !== exp_data)
            $display("FAIL fullpop_xfer: xfer %b leaf %b data %h, want leaf %b data %h", got_xfer, got_vec, got_data, exp_vec, exp_data);
        else passed++;
        total++; if (fifo_level !== 3'd3) $display("FAIL fullpop_level: got %0d want 3", fifo_level); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL fullpop_ready_next: got %b want 1", in_ready); else passed++;
        for (int c = 0; c < 20 && (nxt <= 8 || q.size() > 0 || out_valid != '0); c++) begin
            in_valid = nxt <= 8;
            in_data = W'(nxt);
            tick();
            if (did_push) nxt++;
            if (got_xfer) begin
                total++;
                if (got_vec !== exp_vec || got_data !== exp_data)
                    $display("FAIL resume_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
                else passed++;
            end
        end
        in_valid = 0;
        total++;
        if (q.size() != 0 || fifo_level !== '0 || out_valid !== '0)
            $display("FAIL drain: level %0d valid %b pending %0d, want all 0", fifo_level, out_valid, q.size());
        else passed++;
    endtask

    task automatic test_flush();
        int pushed = 0, delivered = 0;
        flush = 1; tick(); flush = 0;
        out_ready = '1;
        for (int c = 0; c < 20 && delivered < 3; c++) begin
            in_valid = pushed < 3;
            in_data = W'(16'h10 + pushed);
            tick();
            if (did_push) pushed++;
            if (got_xfer) begin
                delivered++;
                total++;
                if (got_vec !== exp_vec || got_data !== exp_data)
                    $display("FAIL preflush_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
                else passed++;
            end
        end
        out_ready = '0;
        pushed = 0;
        for (int c = 0; c < 10 && pushed < 4; c++) begin
            in_valid = 1;
            in_data = W'(16'h20 + pushed);
            tick();
            if (did_push) pushed++;
        end
        in_valid = 0;
        tick();
        total++; if (out_valid !== 5'b01000) $display("FAIL preflush_tgt: got %b want 01000", out_valid); else passed++;
        total++; if (fifo_level !== 3'd3) $display("FAIL preflush_level: got %0d want 3", fifo_level); else passed++;
        flush = 1; in_valid = 1; in_data = 16'hDEAD; out_ready = '1;
        tick();
        flush = 0; in_valid = 0;
        total++; if (out_valid !== '0) $display("FAIL flush_valid: got %b want 0", out_valid); else passed++;
        total++; if (fifo_level !== '0) $display("FAIL flush_level: got %0d want 0", fifo_level); else passed++;
`ifdef LEAF_DISPATCH_CNT_EN
        total++; if (dispatch_cnt !== 32'd0) $display("FAIL flush_cnt: got %0d want 0", dispatch_cnt); else passed++;
`endif
        in_valid = 1; in_data = 16'hABCD;
        tick();
        in_valid = 0;
        tick();
        total++;
        if (out_valid !== 5'b00001 || out_data !== 16'hABCD)
            $display("FAIL postflush_leaf0: leaf %b data %h, want leaf 00001 data abcd", out_valid, out_data);
        else passed++;
        tick();
        total++;
        if (!got_xfer || got_vec !== exp_vec || got_data !== exp_data)
            $display("FAIL postflush_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
        else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = '0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1;
            in_data = W'(16'h40 + c);
            tick();
        end
        in_valid = 0;
        total++; if (out_valid === '0) $display("FAIL async_pre: got %b want nonzero", out_valid); else passed++;
        #2 rst_n = 0;
        #1;
        total++; if (out_valid !== '0) $display("FAIL async_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL async_data: got %h want 0", out_data); else passed++;
        total++; if (fifo_level !== '0) $display("FAIL async_level: got %0d want 0", fifo_level); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL async_ready: got %b want 1", in_ready); else passed++;
        @(negedge clk);
        q.delete(); exp_leaf = 0; exp_cnt = '0;
        rst_n = 1;
    endtask

    task automatic test_random();
        logic stalled;
        logic [N-1:0] snap_vec;
        logic [W-1:0] snap_data;
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = W'($urandom);
            out_ready = N'($urandom);
            flush = $urandom_range(0, 49) == 0;
            stalled = out_valid != '0 && !(|(out_valid & out_ready)) && !flush;
            snap_vec = out_valid;
            snap_data = out_data;
            tick();
            if (got_xfer) begin
                total++;
                if (got_vec !== exp_vec || got_data !== exp_data)
                    $display("FAIL rand_xfer: leaf %b data %h, want leaf %b data %h", got_vec, got_data, exp_vec, exp_data);
                else passed++;
            end
            total++;
            if (int'(fifo_level) + (out_valid != '0 ? 1 : 0) != q.size())
                $display("FAIL rand_occupancy: level %0d valid %b, want %0d words in flight", fifo_level, out_valid, q.size());
            else passed++;
            total++;
            if (in_ready !== (fifo_level != 3'(D)))
                $display("FAIL rand_in_ready: got %b with level %0d", in_ready, fifo_level);
            else passed++;
            total++;
            if ($countones(out_valid) > 1) $display("FAIL rand_onehot: got %b want at most one bit", out_valid);
            else passed++;
            if (stalled) begin
                total++;
                if (out_valid !== snap_vec || out_data !== snap_data)
                    $display("FAIL rand_hold: leaf %b data %h, want leaf %b data %h", out_valid, out_data, snap_vec, snap_data);
                else passed++;
            end
`ifdef LEAF_DISPATCH_CNT_EN
            total++;
            if (dispatch_cnt !== exp_cnt) $display("FAIL rand_cnt: got %0d want %0d", dispatch_cnt, exp_cnt);
            else passed++;
`endif
        end
        flush = 0;
        in_valid = 0;
    endtask

`ifdef LEAF_DISPATCH_CNT_EN
    task automatic test_counter();
        int pushed = 0;
        do_reset();
        out_ready = '1;
        for (int c = 0; c < 40 && (pushed < 12 || q.size() > 0 || out_valid != '0); c++) begin
            in_valid = pushed < 12;
            in_data = W'(pushed);
            tick();
            if (did_push) pushed++;
        end
        in_valid = 0;
        total++; if (dispatch_cnt !== 32'd12) $display("FAIL cnt_12: got %0d want 12", dispatch_cnt); else passed++;
        force dut.dispatch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.dispatch_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        in_valid = 1; in_data = 16'h5A5A;
        tick();
        in_valid = 0;
        for (int c = 0; c < 5 && out_valid != '0; c++) tick();
        total++; if (dispatch_cnt !== 32'd0) $display("FAIL cnt_wrap: got %h want 0", dispatch_cnt); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_order();
        test_stall();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
`ifdef LEAF_DISPATCH_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
